// File: rtl/iter_divider.sv
// iter_divider: 32-bit signed/unsigned restoring divider producing one quotient
// bit per RUN cycle. Results are written to LO (quotient) and HI (remainder).
// Optional build macro DIV_FAST_ZERO_EN: an operation with a zero dividend or
// a zero divisor finishes after a single RUN cycle instead of 32 iterations.
//
// Handshake: start is a level request sampled on each rising clock edge. It is
// accepted only in IDLE or DONE and only when flush is low; a start seen in RUN
// is dropped. Every accepted request produces exactly one done pulse unless a
// flush or reset abandons it first. There is no backpressure on done.
module iter_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sin,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Control strobes derived from the FSM.
    logic        accept;
    logic        last_iter;
    logic        finish;

    // Iteration state. quo starts as the dividend magnitude; dividend bits
    // shift out of its top while quotient bits shift in at the bottom.
    logic [4:0]  count;
    logic [31:0] acc;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
`ifdef DIV_FAST_ZERO_EN
    logic        fast;
`endif

    // Operand magnitudes at accept time.
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // One restoring step.
    logic [32:0] shifted;
    logic [31:0] trial;
    logic        ge;
    logic [31:0] acc_nxt;
    logic [31:0] quo_nxt;

    // Sign-corrected results presented to the output registers.
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_res;
    logic [31:0] r_res;

    assign dbg_state = state;

    // Operand magnitudes: only signed mode with a negative operand is negated.
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        if (sin && dividend[31]) begin
            a_mag = -dividend;
        end
        if (sin && divisor[31]) begin
            b_mag = -divisor;
        end
    end

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits. A set bit 32 after the shift always
    // means the divisor fits, and the low 32 bits of the difference are exact.
    always_comb begin
        shifted = {acc, quo[31]};
        trial   = shifted[31:0] - dsr;
        ge      = shifted[32] | (shifted[31:0] >= dsr);
        acc_nxt = ge ? trial : shifted[31:0];
        quo_nxt = {quo[30:0], ge};
    end

    // Last RUN cycle: 32nd iteration, or the single shortcut cycle.
    always_comb begin
        last_iter = (state == RUN) && (count == 5'd31);
`ifdef DIV_FAST_ZERO_EN
        if ((state == RUN) && fast) begin
            last_iter = 1'b1;
        end
`endif
        finish = last_iter && !flush;
    end

    // Result sign correction; a zero divisor bypasses quotient correction so
    // the quotient is all ones and the remainder reconstructs the dividend.
    always_comb begin
        q_mag = quo_nxt;
        r_mag = acc_nxt;
`ifdef DIV_FAST_ZERO_EN
        if (fast) begin
            q_mag = div_zero ? 32'hFFFF_FFFF : 32'd0;
            r_mag = div_zero ? quo : 32'd0;
        end
`endif
        q_res = div_zero ? 32'hFFFF_FFFF : (neg_q ? -q_mag : q_mag);
        r_res = neg_r ? -r_mag : r_mag;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and status outputs; flush overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            accept    = 1'b0;
            state_nxt = IDLE;
        end
    end

    // Operand capture on accept, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 5'd0;
            acc      <= 32'd0;
            quo      <= 32'd0;
            dsr      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`ifdef DIV_FAST_ZERO_EN
            fast     <= 1'b0;
`endif
        end else if (accept) begin
            count    <= 5'd0;
            acc      <= 32'd0;
            quo      <= a_mag;
            dsr      <= b_mag;
            neg_q    <= sin & (dividend[31] ^ divisor[31]);
            neg_r    <= sin & dividend[31];
            div_zero <= (divisor == 32'd0);
`ifdef DIV_FAST_ZERO_EN
            fast     <= (divisor == 32'd0) || (dividend == 32'd0);
`endif
        end else if (flush) begin
            count    <= 5'd0;
        end else if (state == RUN) begin
            acc      <= acc_nxt;
            quo      <= quo_nxt;
            count    <= count + 5'd1;
        end
    end

    // Output registers change only on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient  <= 32'd0;
            remainder <= 32'd0;
        end else if (finish) begin
            quotient  <= q_res;
            remainder <= r_res;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and randomized checks of iter_divider against an
// arithmetic reference model.
module tb_iter_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sin;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  logic [63:0] exp_q[$];
  logic [31:0] prev_q;
  logic [31:0] prev_r;
  bit          cur_fast;

`ifdef DIV_FAST_ZERO_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  iter_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sin       (sin),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    int sa;
    int sb;
    int qi;
    int ri;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    sa = a;
    sb = b;
    qi = sa / sb;
    ri = sa % sb;
    return {32'(qi), 32'(ri)};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Drive a request now (caller is at a negedge); it is accepted at the next posedge.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit s);
    dividend = a;
    divisor  = b;
    sin      = s;
    start    = 1'b1;
    cur_fast = FAST_EN && (a == 32'd0 || b == 32'd0);
    exp_q.push_back(model(a, b, s));
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(negedge clk);
    drive_start(a, b, s);
  endtask

  // Follow one accepted operation to its done pulse and check it. With chain
  // set, the next request is driven during the DONE cycle.
  task automatic finish_op(input string tag, input bit poke, input bit chain,
                           input logic [31:0] a2, input logic [31:0] b2, input bit s2);
    int busy_n;
    int lat;
    bit f;
    logic [63:0] exp;
    f = cur_fast;
    busy_n = 0;
    lat = -1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        sin      = 1'($urandom_range(0, 1));
      end
      if (poke && !f && n == 10) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom_range(1, 9);
      end
      if (poke && !f && n == 11) start = 1'b0;
      if (!f && n == 1) check({tag, "_hold"}, {quotient, remainder}, {prev_q, prev_r});
      if (done) begin
        lat = n;
        break;
      end
      busy_n += int'(busy);
    end
    check({tag, "_latency"}, 64'(lat), f ? 64'd1 : 64'd32);
    check({tag, "_busy_cycles"}, 64'(busy_n), f ? 64'd1 : 64'd32);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      exp = {prev_q, prev_r};
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_result"}, {quotient, remainder}, exp);
    prev_q = exp[63:32];
    prev_r = exp[31:0];
    last_done_cyc = cyc;
    if (chain) begin
      drive_start(a2, b2, s2);
    end else begin
      @(negedge clk);
      check({tag, "_done_pulse_end"}, {62'd0, dbg_state}, 64'd0);
      check({tag, "_done_low"}, {63'd0, done}, 64'd0);
    end
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_b();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 15));
      3: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int d1;
    logic [31:0] a;
    logic [31:0] b;
    bit s;
    logic [31:0] na;
    logic [31:0] nb;
    bit ns;
    bit ch;

    reset    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    sin      = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    prev_q   = 32'd0;
    prev_r   = 32'd0;
    cur_fast = 1'b0;
    #1;
    check("reset_outputs", {quotient, remainder}, 64'd0);
    check("reset_status", {60'd0, busy, done, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed divisions.
    launch(32'd100, 32'd7, 1'b0);
    finish_op("udiv_100_7", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    finish_op("sdiv_m7_2", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    finish_op("sdiv_overflow", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    finish_op("udiv_big", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'h1234_5678, 32'd0, 1'b0);
    finish_op("udiv_by_zero", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'h1234_5678, 32'd0, 1'b1);
    finish_op("sdiv_by_zero", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'h8000_0005, 32'd0, 1'b1);
    finish_op("sdiv_neg_by_zero", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    launch(32'd0, 32'hFFFF_FFF3, 1'b1);
    finish_op("sdiv_zero_dividend", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Start ignored in RUN, then flush: no done, outputs held, IDLE at k+11.
    launch(32'd9, 32'd2, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 4) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      if (n == 5) start = 1'b0;
      if (n == 9) flush = 1'b1;
      if (n == 10) flush = 1'b0;
      if (n == 11) check("flush_idle_k11", {62'd0, dbg_state}, 64'd0);
      if (done) check("flush_no_done", {63'd0, done}, 64'd0);
    end
    check("flush_outputs_held", {quotient, remainder}, {prev_q, prev_r});

    // flush and start together: flush wins.
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd3;
    start    = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_beats_start", {61'd0, busy, dbg_state}, 64'd0);

    // Back-to-back accept during DONE.
    launch(32'd9, 32'd2, 1'b0);
    finish_op("b2b_first", 1'b0, 1'b1, 32'd50, 32'd5, 1'b0);
    d1 = last_done_cyc;
    finish_op("b2b_second", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("b2b_gap", 64'(last_done_cyc - d1), 64'd33);

    // Asynchronous reset mid-RUN at iteration 16.
    launch(32'hDEAD_BEEF, 32'd7, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
    end
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {quotient, remainder}, 64'd0);
    check("async_reset_status", {60'd0, busy, done, dbg_state}, 64'd0);
    prev_q = 32'd0;
    prev_r = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    launch(32'd20, 32'd3, 1'b0);
    finish_op("after_reset_20_3", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Randomized operations with optional in-RUN pokes and chaining.
    a = rand_a();
    b = rand_b();
    s = 1'($urandom_range(0, 1));
    launch(a, b, s);
    for (int i = 0; i < 30; i++) begin
      na = rand_a();
      nb = rand_b();
      ns = 1'($urandom_range(0, 1));
      ch = (i < 29) && ($urandom_range(0, 2) == 0);
      finish_op("random", 1'($urandom_range(0, 1)), ch, na, nb, ns);
      if (!ch && i < 29) launch(na, nb, ns);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
